credential_checker: RTL and testbench
=====================================

Name: credential_checker

Overview:
- Responder side of the access-controller credential handshake.
- Receives the 4-digit ID with its valid level, searches a small credential table, and returns `idChecked`. Then receives the 4-digit password with its valid level, compares it against the matched entry, and returns `passChecked`.
- Counts failed password attempts and enforces a timed lockout.
- Table entries can be rewritten through a programming port while the checker is idle.

Parameters:
- NUM_USERS, 4, number of credential entries (2..8).
- MAX_FAILS, 3, consecutive wrong passwords before lockout (1..15).
- LOCK_CYCLES, 1000, lockout duration in clk cycles (1..65535).
- DEFAULT_IDS, {16'h1234,16'h2222,16'h3030,16'h9999}, per-entry IDs loaded at reset; entry 0 is in the MS word.
- DEFAULT_PWDS, {16'h5678,16'h0000,16'h4321,16'h1111}, per-entry passwords loaded at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- idValid  in  1  level; high while the ID digits are complete
- idDigits  in  16  {digit1,digit2,digit3,digit4}, digit1 in [15:12]
- pwdValid  in  1  level; high while the password digits are complete
- pwdDigits  in  16  password digits, same packing as idDigits
- progEn  in  1  one-cycle write strobe
- progIndex  in  3  entry to write
- progId  in  16  new ID
- progPwd  in  16  new password
- idChecked  out  1  ID found in table
- passChecked  out  1  password matches the matched entry
- busy  out  1  search or compare in progress
- locked  out  1  lockout active
- failCount  out  4  consecutive wrong-password count
- progErr  out  1  one-cycle pulse; write rejected

Behaviour:
- Reset (rst==0 at a clk edge):
  - all outputs go to 0; FSM goes to IDLE; the lockout timer clears.
  - the table reloads from DEFAULT_*.
  - an in-flight search or compare is discarded.
- FSM states: IDLE, ID_SEARCH, ID_OK, PWD_CHECK, PWD_DONE, LOCKED.
- IDLE:
  - A rising edge of idValid (registered previous value) latches idDigits, clears the search index, sets busy=1 and moves to ID_SEARCH.
- ID_SEARCH:
  - Compares one entry per cycle, index 0 upward.
  - On a hit: store matchIdx, set idChecked=1, busy=0, go to ID_OK. Worst-case latency is NUM_USERS cycles after the edge. The lowest matching index wins.
  - On a miss of the last entry: idChecked stays 0, busy=0, return to IDLE. A new attempt needs a new idValid rising edge.
- ID_OK:
  - A pwdValid rising edge, or any change of pwdDigits while pwdValid=1, latches pwdDigits and goes to PWD_CHECK. The change-detect is what allows retries, because the requester holds pwdValid high across retries.
- PWD_CHECK (1 cycle):
  - Compares against entry[matchIdx] and goes to PWD_DONE.
  - Match: passChecked=1 and failCount=0.
  - Mismatch: passChecked=0 and failCount+1. If the count reaches MAX_FAILS, load the timer with LOCK_CYCLES and go to LOCKED instead.
- PWD_DONE:
  - passChecked=1 holds until idValid falls.
  - A mismatch re-arms the same trigger as ID_OK.
- LOCKED:
  - locked=1, idChecked=0, passChecked=0, all triggers ignored.
  - The timer decrements each cycle. At 0: locked=0, failCount=0, go to IDLE.
- idValid falling in any state except LOCKED:
  - idChecked=0, passChecked=0, busy=0, go to IDLE next cycle.
  - failCount is retained; it is cleared only by a correct password, lockout expiry, or reset.
- Programming:
  - progEn is accepted only in IDLE with progIndex<NUM_USERS. The write lands at the next edge.
  - Otherwise progErr pulses for 1 cycle and the table is unchanged.
  - If progEn and an idValid rising edge coincide in IDLE, the write takes effect first and the search sees the new entry.
- failCount saturates at MAX_FAILS and never wraps.

Decomposition:
- Package credential_pkg: FSM state encoding, DIGIT_W=4, CRED_W=16, IDX_W=3, LOCK_W=16.
- Sub-module credential_table: NUM_USERS x (ID,PWD) register file.
  - Synchronous write port and reset-to-default load.
  - Two combinational read ports: search index and matchIdx.

Test Plan:
- Reset, then idValid rises with idDigits=16'h3030 → busy=1 for 3 cycles; idChecked=1 on cycle 3 (matchIdx=2), busy=0.
- After the hit, pwdValid rises with pwdDigits=16'h4321 → passChecked=1 one cycle later with failCount=0. Dropping idValid returns both checks to 0 the next cycle.
- idDigits=16'hABCD → 4 cycles of busy, then idChecked remains 0 and the FSM returns to IDLE. A second idValid edge is required before another search starts.
- ID 16'h1234, then passwords 16'h0001, 16'h0002, 16'h0003 applied as digit changes under held pwdValid → failCount steps 1,2,3, then locked=1. With LOCK_CYCLES=8, locked clears after 8 cycles and failCount=0.
- IDLE progEn with progIndex=1, progId=16'h7777, progPwd=16'h8888, then ID 16'h7777 with password 16'h8888 → idChecked=1 after 2 cycles, then passChecked=1.
- Error and reset cases:
  - progEn during ID_SEARCH → progErr pulses and the table is unchanged.
  - progIndex=5 in IDLE → progErr pulses.
  - rst=0 mid-search → all outputs 0 and the table returns to defaults.

Source files
------------

// File: rtl/credential_pkg.sv
// Shared types and widths for the credential checker.
// Contents:
//   cred_state_e - checker FSM states
//   DIGIT_W, CRED_W, IDX_W, LOCK_W - field widths
package credential_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CRED_W  = 4 * DIGIT_W;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned LOCK_W  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIdSearch,
        StIdOk,
        StPwdCheck,
        StPwdDone,
        StLocked
    } cred_state_e;

endpackage

// File: rtl/credential_table.sv
// NUM_USERS x (ID, password) register file with reset-to-default load.
// Ports:
//   clk_i, rst_ni          - clock, synchronous active-low reset (reloads defaults)
//   we_i, widx_i           - write strobe and entry index
//   wid_i, wpwd_i          - new ID / password for the written entry
//   sidx_i -> sid_o        - combinational ID read for the search walk
//   midx_i -> mpwd_o       - combinational password read for the matched entry
module credential_table
    import credential_pkg::*;
#(
    parameter int unsigned                  NUM_USERS    = 4,
    parameter logic [NUM_USERS*CRED_W-1:0]  DEFAULT_IDS  = {16'h1234, 16'h2222, 16'h3030, 16'h9999},
    parameter logic [NUM_USERS*CRED_W-1:0]  DEFAULT_PWDS = {16'h5678, 16'h0000, 16'h4321, 16'h1111}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [CRED_W-1:0] wid_i,
    input  logic [CRED_W-1:0] wpwd_i,
    input  logic [IDX_W-1:0]  sidx_i,
    output logic [CRED_W-1:0] sid_o,
    input  logic [IDX_W-1:0]  midx_i,
    output logic [CRED_W-1:0] mpwd_o
);

    logic [CRED_W-1:0] ids_q  [NUM_USERS];
    logic [CRED_W-1:0] pwds_q [NUM_USERS];

    // Entry 0 lives in the most-significant word of the default vectors.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_USERS; i++) begin
            if (!rst_ni) begin
                ids_q[i]  <= DEFAULT_IDS[(NUM_USERS-1-i)*CRED_W +: CRED_W];
                pwds_q[i] <= DEFAULT_PWDS[(NUM_USERS-1-i)*CRED_W +: CRED_W];
            end else if (we_i && (widx_i == IDX_W'(i))) begin
                ids_q[i]  <= wid_i;
                pwds_q[i] <= wpwd_i;
            end
        end
    end

    // Mux-by-compare keeps out-of-range indices harmless for any NUM_USERS.
    always_comb begin
        sid_o  = '0;
        mpwd_o = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (sidx_i == IDX_W'(i)) sid_o = ids_q[i];
            if (midx_i == IDX_W'(i)) mpwd_o = pwds_q[i];
        end
    end

endmodule

// File: rtl/credential_checker.sv
// Responder side of the ID/password handshake with failed-attempt lockout.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   idValid, idDigits        - ID level-valid and 4 BCD-style digits
//   pwdValid, pwdDigits      - password level-valid and digits
//   progEn, progIndex,
//   progId, progPwd          - table write port (accepted only when idle)
//   idChecked, passChecked   - ID found / password matched (registered)
//   busy, locked             - search/compare in progress, lockout active
//   failCount                - consecutive wrong-password count
//   progErr                  - one-cycle pulse when a table write is rejected
module credential_checker
    import credential_pkg::*;
#(
    parameter int unsigned                  NUM_USERS    = 4,
    parameter int unsigned                  MAX_FAILS    = 3,
    parameter int unsigned                  LOCK_CYCLES  = 1000,
    parameter logic [NUM_USERS*CRED_W-1:0]  DEFAULT_IDS  = {16'h1234, 16'h2222, 16'h3030, 16'h9999},
    parameter logic [NUM_USERS*CRED_W-1:0]  DEFAULT_PWDS = {16'h5678, 16'h0000, 16'h4321, 16'h1111}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idValid,
    input  logic [CRED_W-1:0] idDigits,
    input  logic              pwdValid,
    input  logic [CRED_W-1:0] pwdDigits,
    input  logic              progEn,
    input  logic [IDX_W-1:0]  progIndex,
    input  logic [CRED_W-1:0] progId,
    input  logic [CRED_W-1:0] progPwd,
    output logic              idChecked,
    output logic              passChecked,
    output logic              busy,
    output logic              locked,
    output logic [3:0]        failCount,
    output logic              progErr
);

    localparam logic [IDX_W:0]    NumUsersW = (IDX_W + 1)'(NUM_USERS);
    localparam logic [IDX_W-1:0]  LastIdx   = IDX_W'(NUM_USERS - 1);
    localparam logic [3:0]        MaxFailsW = 4'(MAX_FAILS);
    localparam logic [LOCK_W-1:0] LockInit  = LOCK_W'(LOCK_CYCLES);

    cred_state_e       state_q;
    logic              id_valid_q, pwd_valid_q;
    logic [CRED_W-1:0] pwd_prev_q, id_q, pwd_q;
    logic [IDX_W-1:0]  search_idx_q, match_idx_q;
    logic [LOCK_W-1:0] timer_q;
    logic              id_chk_q, pass_q, busy_q, locked_q, prog_err_q;
    logic [3:0]        fail_q;

    logic              id_rise, id_fall, pwd_trig, prog_ok;
    logic [3:0]        fail_inc;
    logic [CRED_W-1:0] search_id, match_pwd;

    assign id_rise  = idValid & ~id_valid_q;
    assign id_fall  = ~idValid & id_valid_q;
    // Retries arrive as digit changes while pwdValid stays high.
    assign pwd_trig = pwdValid & (~pwd_valid_q | (pwdDigits != pwd_prev_q));
    assign prog_ok  = progEn & (state_q == StIdle) & ({1'b0, progIndex} < NumUsersW);
    assign fail_inc = (fail_q < MaxFailsW) ? fail_q + 4'd1 : fail_q;

    credential_table #(
        .NUM_USERS   (NUM_USERS),
        .DEFAULT_IDS (DEFAULT_IDS),
        .DEFAULT_PWDS(DEFAULT_PWDS)
    ) u_table (
        .clk_i (clk),
        .rst_ni(rst),
        .we_i  (prog_ok),
        .widx_i(progIndex),
        .wid_i (progId),
        .wpwd_i(progPwd),
        .sidx_i(search_idx_q),
        .sid_o (search_id),
        .midx_i(match_idx_q),
        .mpwd_o(match_pwd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            id_valid_q   <= 1'b0;
            pwd_valid_q  <= 1'b0;
            pwd_prev_q   <= '0;
            id_q         <= '0;
            pwd_q        <= '0;
            search_idx_q <= '0;
            match_idx_q  <= '0;
            timer_q      <= '0;
            id_chk_q     <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= '0;
            prog_err_q   <= 1'b0;
        end else begin
            id_valid_q  <= idValid;
            pwd_valid_q <= pwdValid;
            pwd_prev_q  <= pwdDigits;
            prog_err_q  <= progEn & ~prog_ok;

            if (id_fall && (state_q != StLocked)) begin
                // Requester abandoned the session; failCount is kept.
                state_q  <= StIdle;
                id_chk_q <= 1'b0;
                pass_q   <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (id_rise) begin
                            id_q         <= idDigits;
                            search_idx_q <= '0;
                            busy_q       <= 1'b1;
                            state_q      <= StIdSearch;
                        end
                    end
                    StIdSearch: begin
                        if (search_id == id_q) begin
                            match_idx_q <= search_idx_q;
                            id_chk_q    <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= StIdOk;
                        end else if (search_idx_q == LastIdx) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            search_idx_q <= search_idx_q + 1'b1;
                        end
                    end
                    StIdOk, StPwdDone: begin
                        // A passed check is final until idValid drops.
                        if (pwd_trig && !(state_q == StPwdDone && pass_q)) begin
                            pwd_q   <= pwdDigits;
                            busy_q  <= 1'b1;
                            state_q <= StPwdCheck;
                        end
                    end
                    StPwdCheck: begin
                        busy_q <= 1'b0;
                        if (match_pwd == pwd_q) begin
                            pass_q  <= 1'b1;
                            fail_q  <= '0;
                            state_q <= StPwdDone;
                        end else if (fail_inc >= MaxFailsW) begin
                            pass_q   <= 1'b0;
                            fail_q   <= fail_inc;
                            id_chk_q <= 1'b0;
                            locked_q <= 1'b1;
                            timer_q  <= LockInit;
                            state_q  <= StLocked;
                        end else begin
                            pass_q  <= 1'b0;
                            fail_q  <= fail_inc;
                            state_q <= StPwdDone;
                        end
                    end
                    StLocked: begin
                        // Exit on the edge where the timer would reach zero.
                        if (timer_q <= LOCK_W'(1)) begin
                            timer_q  <= '0;
                            locked_q <= 1'b0;
                            fail_q   <= '0;
                            state_q  <= StIdle;
                        end else begin
                            timer_q <= timer_q - LOCK_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign idChecked   = id_chk_q;
    assign passChecked = pass_q;
    assign busy        = busy_q;
    assign locked      = locked_q;
    assign failCount   = fail_q;
    assign progErr     = prog_err_q;

endmodule

// File: tb/tb_credential_checker.sv
// Self-checking bench for credential_checker against a table-level reference model.
module tb_credential_checker;

    localparam int unsigned NumUsers   = 4;
    localparam int unsigned MaxFails   = 3;
    localparam int unsigned LockCycles = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        idValid = 1'b0, pwdValid = 1'b0, progEn = 1'b0;
    logic [15:0] idDigits = '0, pwdDigits = '0, progId = '0, progPwd = '0;
    logic [2:0]  progIndex = '0;
    logic        idChecked, passChecked, busy, locked, progErr;
    logic [3:0]  failCount;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_ids  [NumUsers];
    logic [15:0] m_pwds [NumUsers];
    int          m_fail = 0;
    logic [15:0] last_pwd = '0;

    credential_checker #(
        .NUM_USERS  (NumUsers),
        .MAX_FAILS  (MaxFails),
        .LOCK_CYCLES(LockCycles)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .idValid    (idValid),
        .idDigits   (idDigits),
        .pwdValid   (pwdValid),
        .pwdDigits  (pwdDigits),
        .progEn     (progEn),
        .progIndex  (progIndex),
        .progId     (progId),
        .progPwd    (progPwd),
        .idChecked  (idChecked),
        .passChecked(passChecked),
        .busy       (busy),
        .locked     (locked),
        .failCount  (failCount),
        .progErr    (progErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_find(input logic [15:0] id);
        for (int i = 0; i < NumUsers; i++) if (m_ids[i] == id) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_ids  = '{16'h1234, 16'h2222, 16'h3030, 16'h9999};
        m_pwds = '{16'h5678, 16'h0000, 16'h4321, 16'h1111};
        m_fail = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b0; idValid = 1'b0; pwdValid = 1'b0; progEn = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic all_zero(input string tag);
        checks++;
        if ({idChecked, passChecked, busy, locked, failCount, progErr} !== 9'b0) begin
            errors++;
            $display("FAIL %s: outputs=%b expected all 0", tag,
                     {idChecked, passChecked, busy, locked, failCount, progErr});
        end
    endtask

    // Raise idValid and follow the search; returns the model's hit index or -1.
    task automatic do_id(input logic [15:0] id, input string tag, output int idx);
        int   n;
        logic hit;
        idx = model_find(id);
        hit = (idx >= 0);
        n   = hit ? idx + 1 : NumUsers;
        idDigits = id;
        idValid  = 1'b1;
        tick();
        for (int c = 0; c < n; c++) begin
            checks++;
            if ({busy, idChecked} !== 2'b10) begin
                errors++;
                $display("FAIL %s search cycle %0d: busy,idChecked=%b expected 10",
                         tag, c, {busy, idChecked});
            end
            tick();
        end
        checks++;
        if ({busy, idChecked} !== {1'b0, hit}) begin
            errors++;
            $display("FAIL %s search end: busy,idChecked=%b expected %b",
                     tag, {busy, idChecked}, {1'b0, hit});
        end
    endtask

    // Present a password (rising pwdValid or a digit change) and check the verdict.
    task automatic do_pwd(input logic [15:0] pwd_in, input logic first, input int idx,
                          input string tag, output logic done);
        logic [15:0] pwd;
        logic        exp_pass, exp_lock;
        pwd = pwd_in;
        if (!first && pwd == last_pwd) pwd = pwd ^ 16'h0001;
        last_pwd  = pwd;
        pwdDigits = pwd;
        pwdValid  = 1'b1;
        tick();
        tick();
        exp_pass = (pwd == m_pwds[idx]);
        if (exp_pass) m_fail = 0;
        else if (m_fail < MaxFails) m_fail++;
        exp_lock = !exp_pass && (m_fail >= MaxFails);
        checks++;
        if ({passChecked, failCount, locked, idChecked} !==
            {exp_pass, 4'(m_fail), exp_lock, !exp_lock}) begin
            errors++;
            $display("FAIL %s pwd %h: pass,fail,locked,idChk=%b expected %b", tag, pwd,
                     {passChecked, failCount, locked, idChecked},
                     {exp_pass, 4'(m_fail), exp_lock, !exp_lock});
        end
        done = exp_pass || exp_lock;
        if (exp_lock) begin
            for (int c = 1; c < LockCycles; c++) begin
                if (c == 2) pwdDigits = pwd ^ 16'h0F0F;
                tick();
                checks++;
                if ({locked, passChecked, idChecked, busy} !== 4'b1000) begin
                    errors++;
                    $display("FAIL %s lock cycle %0d: locked,pass,idChk,busy=%b expected 1000",
                             tag, c, {locked, passChecked, idChecked, busy});
                end
            end
            tick();
            m_fail = 0;
            checks++;
            if ({locked, failCount} !== 5'b0) begin
                errors++;
                $display("FAIL %s lock release: locked,failCount=%b expected 00000",
                         tag, {locked, failCount});
            end
        end
    endtask

    task automatic end_session(input string tag);
        idValid  = 1'b0;
        pwdValid = 1'b0;
        tick();
        checks++;
        if ({idChecked, passChecked, busy, locked, failCount} !== {4'b0000, 4'(m_fail)}) begin
            errors++;
            $display("FAIL %s end: idChk,pass,busy,locked,fail=%b expected %b", tag,
                     {idChecked, passChecked, busy, locked, failCount}, {4'b0000, 4'(m_fail)});
        end
        tick();
    endtask

    task automatic do_prog(input logic [2:0] idx, input logic [15:0] id, input logic [15:0] pwd,
                           input string tag);
        logic exp_err;
        exp_err   = (idx >= NumUsers);
        progEn    = 1'b1;
        progIndex = idx;
        progId    = id;
        progPwd   = pwd;
        tick();
        progEn = 1'b0;
        checks++;
        if (progErr !== exp_err) begin
            errors++;
            $display("FAIL %s progErr=%b expected %b", tag, progErr, exp_err);
        end
        if (!exp_err) begin
            m_ids[idx]  = id;
            m_pwds[idx] = pwd;
        end
        tick();
        checks++;
        if (progErr !== 1'b0) begin
            errors++;
            $display("FAIL %s progErr pulse width: got %b expected 0", tag, progErr);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        all_zero("reset");
    endtask

    task automatic test_id_hit_pwd_ok();
        int   idx;
        logic done;
        do_id(16'h3030, "hit3030", idx);
        if (idx >= 0) do_pwd(16'h4321, 1'b1, idx, "hit3030", done);
        end_session("hit3030");
    endtask

    task automatic test_id_miss();
        int idx;
        do_id(16'hABCD, "miss", idx);
        repeat (3) begin
            tick();
            checks++;
            if ({busy, idChecked} !== 2'b00) begin
                errors++;
                $display("FAIL miss hold: busy,idChecked=%b expected 00", {busy, idChecked});
            end
        end
        end_session("miss");
    endtask

    task automatic test_lockout();
        int   idx;
        logic done;
        do_id(16'h1234, "lock", idx);
        if (idx >= 0) begin
            do_pwd(16'h0001, 1'b1, idx, "lock1", done);
            do_pwd(16'h0002, 1'b0, idx, "lock2", done);
            do_pwd(16'h0003, 1'b0, idx, "lock3", done);
        end
        end_session("lock");
    endtask

    task automatic test_program();
        int   idx;
        logic done;
        do_prog(3'd1, 16'h7777, 16'h8888, "prog1");
        do_id(16'h7777, "prog1", idx);
        if (idx >= 0) do_pwd(16'h8888, 1'b1, idx, "prog1", done);
        // A passed check must ignore later digit changes.
        pwdDigits = 16'h0101;
        tick();
        tick();
        checks++;
        if ({passChecked, busy} !== 2'b10) begin
            errors++;
            $display("FAIL pass hold: pass,busy=%b expected 10", {passChecked, busy});
        end
        end_session("prog1");
    endtask

    task automatic test_prog_errors();
        int   idx;
        logic done;
        do_prog(3'd5, 16'h5555, 16'h5555, "prog_idx5");
        // Write attempt during a search must be rejected.
        idx = model_find(16'h9999);
        idDigits = 16'h9999;
        idValid  = 1'b1;
        tick();
        progEn = 1'b1; progIndex = 3'd3; progId = 16'h0BAD; progPwd = 16'h0BAD;
        tick();
        progEn = 1'b0;
        checks++;
        if ({progErr, busy} !== 2'b11) begin
            errors++;
            $display("FAIL prog_busy: progErr,busy=%b expected 11", {progErr, busy});
        end
        repeat (idx) tick();
        checks++;
        if ({busy, idChecked, progErr} !== 3'b010) begin
            errors++;
            $display("FAIL prog_busy table intact: busy,idChk,progErr=%b expected 010",
                     {busy, idChecked, progErr});
        end
        end_session("prog_busy");
        // Write coinciding with the idValid edge is visible to that search.
        progEn = 1'b1; progIndex = 3'd0; progId = 16'hABCD; progPwd = 16'h1357;
        idDigits = 16'hABCD;
        idValid  = 1'b1;
        tick();
        progEn = 1'b0;
        m_ids[0]  = 16'hABCD;
        m_pwds[0] = 16'h1357;
        checks++;
        if ({progErr, busy} !== 2'b01) begin
            errors++;
            $display("FAIL prog_coincide: progErr,busy=%b expected 01", {progErr, busy});
        end
        tick();
        checks++;
        if ({busy, idChecked} !== 2'b01) begin
            errors++;
            $display("FAIL prog_coincide hit: busy,idChk=%b expected 01", {busy, idChecked});
        end
        do_pwd(16'h1357, 1'b1, 0, "prog_coincide", done);
        end_session("prog_coincide");
    endtask

    task automatic test_reset_mid_search();
        int   idx;
        logic done;
        do_id(16'h3030, "rst_pre", idx);
        if (idx >= 0) do_pwd(16'h0000, 1'b1, idx, "rst_pre", done);
        end_session("rst_pre");
        idDigits = 16'h9999;
        idValid  = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        idValid = 1'b0;
        tick();
        all_zero("rst_mid");
        rst = 1'b1;
        model_reset();
        tick();
        do_id(16'h1234, "rst_default0", idx);
        end_session("rst_default0");
        do_id(16'h7777, "rst_default1", idx);
        end_session("rst_default1");
    endtask

    task automatic test_random();
        int          idx;
        logic        done;
        logic [15:0] id, pwd;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                id = ($urandom_range(0, 1) == 1) ? m_ids[$urandom_range(0, NumUsers-1)]
                                                 : 16'($urandom);
                do_prog(3'($urandom_range(0, 5)), id, 16'($urandom), "rand_prog");
            end
            if ($urandom_range(0, 3) != 0) id = m_ids[$urandom_range(0, NumUsers-1)];
            else id = 16'($urandom);
            do_id(id, "rand_id", idx);
            if (idx >= 0) begin
                done = 1'b0;
                for (int a = 0; a < 4 && !done; a++) begin
                    pwd = ($urandom_range(0, 1) == 1) ? m_pwds[idx] : 16'($urandom);
                    do_pwd(pwd, (a == 0), idx, "rand_pwd", done);
                end
            end
            end_session("rand");
        end
    endtask

    initial begin
        test_reset();
        test_id_hit_pwd_ok();
        test_id_miss();
        test_lockout();
        test_program();
        test_prog_errors();
        test_reset_mid_search();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
